// File: rtl/mont_modexp.sv
// Montgomery modular exponentiation res = m^e mod n. It uses a bit-serial radix-2 MonPro core
// and scans the exponent left to right. Define MODEXP_R2_CALC_EN to derive R^2 mod n internally.
module mont_modexp #(
    parameter int WIDTH     = 64,
    parameter int EXP_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     m_input,
    input  logic [EXP_WIDTH-1:0] e_input,
    input  logic [WIDTH-1:0]     n_input,
    input  logic [WIDTH-1:0]     r2_input,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     res_out,
    output logic [2:0]           state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int EB = $clog2(EXP_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0, R2CALC = 3'd1, TOM = 3'd2, TOX = 3'd3,
        SQR  = 3'd4, MUL    = 3'd5, FRM = 3'd6, DONE = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d, n_q, n_d, r2_q, r2_d, mm_q, mm_d, x_q, x_d, res_q, res_d;
    logic [EXP_WIDTH-1:0] e_q, e_d;
    logic [WIDTH+1:0]     u_q, u_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [EB-1:0]        bit_q, bit_d;
    logic                 err_q, err_d;
`ifdef MODEXP_R2_CALC_EN
    localparam int RW = $clog2(2 * WIDTH);
    logic [RW-1:0]        rc_q, rc_d;
    logic [WIDTH:0]       r_x2;
    logic [WIDTH-1:0]     r_dbl;
    logic                 unused_r2;
    assign unused_r2 = ^r2_input;
    assign r_x2  = {r2_q, 1'b0};
    assign r_dbl = (r_x2 >= {1'b0, n_q}) ? WIDTH'(r_x2 - {1'b0, n_q}) : WIDTH'(r_x2);
`endif

    // Operand routing for the shared MonPro core; X only changes at the end of a product.
    logic [WIDTH-1:0] a_op, b_op, mp_res;
    always_comb begin
        a_op = x_q;
        b_op = x_q;
        case (state_q)
            TOM:     begin a_op = m_q;       b_op = r2_q;      end
            TOX:     begin a_op = WIDTH'(1); b_op = r2_q;      end
            MUL:     begin a_op = mm_q;      b_op = x_q;       end
            FRM:     begin a_op = x_q;       b_op = WIDTH'(1); end
            default: ;
        endcase
    end

    logic             abit, ebit, mp_last;
    logic [WIDTH+1:0] t_sum, u_step;
    assign abit    = |(a_op & (WIDTH'(1) << cnt_q));
    assign ebit    = |(e_q & (EXP_WIDTH'(1) << bit_q));
    assign mp_last = (cnt_q == CW'(WIDTH));
    assign t_sum   = u_q + (abit ? {2'b00, b_op} : '0);
    assign u_step  = (t_sum + (t_sum[0] ? {2'b00, n_q} : '0)) >> 1;
    assign mp_res  = (u_q >= {2'b00, n_q}) ? WIDTH'(u_q - {2'b00, n_q}) : WIDTH'(u_q);

    always_comb begin
        state_d = state_q;
        m_d = m_q; e_d = e_q; n_d = n_q; r2_d = r2_q;
        mm_d = mm_q; x_d = x_q; res_d = res_q; err_d = err_q;
        u_d = u_q; cnt_d = cnt_q; bit_d = bit_q;
`ifdef MODEXP_R2_CALC_EN
        rc_d = rc_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d = m_input; e_d = e_input; n_d = n_input;
                    res_d = '0; err_d = 1'b0; u_d = '0; cnt_d = '0;
                    bit_d = EB'(EXP_WIDTH - 1);
`ifdef MODEXP_R2_CALC_EN
                    r2_d = WIDTH'(1);
                    rc_d = '0;
                    state_d = R2CALC;
`else
                    r2_d = r2_input;
                    state_d = TOM;
`endif
                    if (!n_input[0] || n_input == WIDTH'(1) || m_input >= n_input) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
`ifdef MODEXP_R2_CALC_EN
            R2CALC: begin
                r2_d = r_dbl;
                rc_d = rc_q + 1'b1;
                if (rc_q == RW'(2 * WIDTH - 1)) state_d = TOM;
            end
`endif
            DONE: state_d = IDLE;
            default: begin
                if (!mp_last) begin
                    u_d   = u_step;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    u_d   = '0;
                    cnt_d = '0;
                    case (state_q)
                        TOM: begin mm_d = mp_res; state_d = TOX; end
                        TOX: begin x_d  = mp_res; state_d = SQR; end
                        SQR: begin
                            x_d = mp_res;
                            if (ebit)              state_d = MUL;
                            else if (bit_q == '0)  state_d = FRM;
                            else begin bit_d = bit_q - 1'b1; state_d = SQR; end
                        end
                        MUL: begin
                            x_d = mp_res;
                            if (bit_q == '0) state_d = FRM;
                            else begin bit_d = bit_q - 1'b1; state_d = SQR; end
                        end
                        default: begin res_d = mp_res; state_d = DONE; end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            m_q <= '0; e_q <= '0; n_q <= '0; r2_q <= '0;
            mm_q <= '0; x_q <= '0; res_q <= '0; err_q <= 1'b0;
            u_q <= '0; cnt_q <= '0; bit_q <= '0;
`ifdef MODEXP_R2_CALC_EN
            rc_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            m_q <= m_d; e_q <= e_d; n_q <= n_d; r2_q <= r2_d;
            mm_q <= mm_d; x_q <= x_d; res_q <= res_d; err_q <= err_d;
            u_q <= u_d; cnt_q <= cnt_d; bit_q <= bit_d;
`ifdef MODEXP_R2_CALC_EN
            rc_q <= rc_d;
`endif
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign res_out = res_q;
    assign state   = state_q;
endmodule

// File: tb/tb_mont_modexp.sv
// Self-checking bench for mont_modexp: an 8-bit instance and a default 64-bit instance,
// checked against a plain square-and-multiply reference through a result scoreboard.
module tb_mont_modexp;
`ifdef MODEXP_R2_CALC_EN
    localparam int R2X = 1;
`else
    localparam int R2X = 0;
`endif

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk, reset;
    logic        s_start, s_busy, s_done, s_err;
    logic [7:0]  s_m, s_e, s_n, s_r2, s_res;
    logic [2:0]  s_state;
    logic        w_start, w_busy, w_done, w_err;
    logic [63:0] w_m, w_e, w_n, w_r2, w_res;
    logic [2:0]  w_state;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    mont_modexp #(.WIDTH(8), .EXP_WIDTH(8)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .m_input(s_m), .e_input(s_e),
        .n_input(s_n), .r2_input(s_r2), .busy(s_busy), .done(s_done), .err(s_err),
        .res_out(s_res), .state(s_state)
    );

    mont_modexp u_wide (
        .clk(clk), .reset(reset), .start(w_start), .m_input(w_m), .e_input(w_e),
        .n_input(w_n), .r2_input(w_r2), .busy(w_busy), .done(w_done), .err(w_err),
        .res_out(w_res), .state(w_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic exp_t model(input bit wide, input logic [63:0] m, e, n);
        exp_t        x;
        logic [127:0] acc;
        int          w;
        w = wide ? 64 : 8;
        x.res = '0; x.err = 1'b0; x.lat = 0;
        if (!n[0] || n == 64'd1 || m >= n) begin
            x.err = 1'b1;
        end else begin
            acc = 128'd1;
            for (int j = w - 1; j >= 0; j--) begin
                acc = (acc * acc) % {64'd0, n};
                if (e[j]) acc = (acc * {64'd0, m}) % {64'd0, n};
            end
            x.res = acc[63:0];
            x.lat = (3 + w + $countones(e)) * (w + 1) + R2X * 2 * w;
        end
        return x;
    endfunction

    function automatic logic [63:0] r2_of(input logic [63:0] n, input int w);
        logic [128:0] p;
        p = 129'd1 << (2 * w);
        p = p % {65'd0, n};
        return p[63:0];
    endfunction

    task automatic run_op(input bit wide, input logic [63:0] m, e, n, r2, input int intrude_at);
        exp_t        x, got_x;
        int          cyc;
        logic        seen;
        logic [63:0] r_got;
        x = model(wide, m, e, n);
        sb.push_back(x);
        @(negedge clk);
        if (wide) begin
            w_m = m; w_e = e; w_n = n; w_r2 = r2; w_start = 1'b1;
        end else begin
            s_m = m[7:0]; s_e = e[7:0]; s_n = n[7:0]; s_r2 = r2[7:0]; s_start = 1'b1;
        end
        @(posedge clk); #1;
        s_start = 1'b0; w_start = 1'b0;
        cyc  = 0;
        seen = wide ? w_done : s_done;
        while (!seen && cyc < x.lat + 64) begin
            if (!wide && cyc == intrude_at) begin
                s_start = 1'b1; s_m = 8'h07; s_e = 8'hFF; s_n = 8'hBD; s_r2 = 8'h11;
            end
            @(posedge clk); #1;
            cyc++;
            if (!wide && cyc == intrude_at + 1) begin
                s_start = 1'b0;
                chk("busy_on_ignored_start", {63'd0, s_busy}, 64'd1);
            end
            seen = wide ? w_done : s_done;
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        got_x = sb.pop_front();
        r_got = wide ? w_res : {56'd0, s_res};
        chk("res_out", r_got, got_x.res);
        chk("err", {63'd0, wide ? w_err : s_err}, {63'd0, got_x.err});
        chk("latency", 64'(cyc), 64'(got_x.lat));
        chk("busy_in_done", {63'd0, wide ? w_busy : s_busy}, 64'd1);
        @(posedge clk); #1;
        chk("done_pulse_end", {63'd0, wide ? w_done : s_done}, 64'd0);
        chk("busy_after_done", {63'd0, wide ? w_busy : s_busy}, 64'd0);
        r_got = wide ? w_res : {56'd0, s_res};
        chk("res_held", r_got, got_x.res);
    endtask

    initial begin
        logic [63:0] n, m, e;
        int          cyc, ndone;
        reset = 1'b0;
        s_start = 1'b0; s_m = '0; s_e = '0; s_n = '0; s_r2 = '0;
        w_start = 1'b0; w_m = '0; w_e = '0; w_n = '0; w_r2 = '0;
        #12;
        chk("rst_state", {61'd0, s_state}, 64'd0);
        chk("rst_busy",  {63'd0, s_busy},  64'd0);
        chk("rst_done",  {63'd0, s_done},  64'd0);
        chk("rst_err",   {63'd0, s_err},   64'd0);
        chk("rst_res",   {56'd0, s_res},   64'd0);
        chk("rst_wide_res", w_res, 64'd0);
        @(negedge clk); reset = 1'b1;

        // Directed 8-bit cases, including the ignored mid-run start.
        run_op(1'b0, 64'h05, 64'h03, 64'hBB, 64'h56, -1);
`ifdef MODEXP_R2_CALC_EN
        run_op(1'b0, 64'h05, 64'h03, 64'hBB, 64'h00, -1);
`endif
        run_op(1'b0, 64'h05, 64'h00, 64'hBB, 64'h56, 20);
        run_op(1'b0, 64'h05, 64'h03, 64'hBC, 64'h00, -1);
        run_op(1'b0, 64'hBB, 64'h03, 64'hBB, 64'h56, -1);
        run_op(1'b0, 64'hC0, 64'h03, 64'hBB, 64'h56, -1);
        run_op(1'b0, 64'h00, 64'h03, 64'h01, 64'h00, -1);
        run_op(1'b0, 64'h00, 64'h05, 64'hBB, 64'h56, -1);
        run_op(1'b0, 64'h00, 64'h00, 64'hBB, 64'h56, -1);
        run_op(1'b0, 64'hBA, 64'hFF, 64'hBB, 64'h56, -1);
        run_op(1'b0, 64'h02, 64'h81, 64'h03, r2_of(64'h03, 8), -1);

        for (int i = 0; i < 48; i++) begin
            n = 64'($urandom_range(1, 127) * 2 + 1);
            m = 64'($urandom) % n;
            e = 64'($urandom_range(0, 255));
            run_op(1'b0, m, e, n, r2_of(n, 8), -1);
        end

        n = 64'h31986649780FA7EF;
        run_op(1'b1, 64'h2, 64'hA, n, r2_of(n, 64), -1);
        for (int i = 0; i < 3; i++) begin
            n = {$urandom, $urandom} | 64'd1;
            if (n == 64'd1) n = 64'd3;
            m = {$urandom, $urandom} % n;
            e = {$urandom, $urandom};
            run_op(1'b1, m, e, n, r2_of(n, 64), -1);
        end

        // Asynchronous abort in the middle of squaring.
        @(negedge clk);
        s_m = 8'h05; s_e = 8'h03; s_n = 8'hBB; s_r2 = 8'h56; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        cyc = 0;
        while (s_state !== 3'd4 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reached_sqr", {61'd0, s_state}, 64'd4);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_state", {61'd0, s_state}, 64'd0);
        chk("abort_busy",  {63'd0, s_busy},  64'd0);
        chk("abort_done",  {63'd0, s_done},  64'd0);
        chk("abort_err",   {63'd0, s_err},   64'd0);
        chk("abort_res",   {56'd0, s_res},   64'd0);
        @(negedge clk); reset = 1'b1;
        ndone = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (s_done) ndone++;
        end
        chk("no_done_after_abort", 64'(ndone), 64'd0);
        run_op(1'b0, 64'h05, 64'h03, 64'hBB, 64'h56, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
